// File: rtl/cmp_arbiter.sv
// ============================================================================
// cmp_arbiter
// ----------------------------------------------------------------------------
// Two-requester front end for a single shared RV32I branch comparator.
// Each cycle at most one request is accepted. It is chosen round-robin when
// both requesters are valid. Its operands are evaluated by one 33-bit
// subtract, and the branch decision, raw flags, requester id and tag are
// captured into a one-entry result register. The result appears one cycle
// after the handshake and is held stable until the consumer accepts it. A
// held result can be drained and replaced in the same cycle.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_reset          synchronous active-high reset
//   i_reqN_valid     requester N (0/1) presents a compare request
//   o_reqN_ready     requester N request accepted this cycle (with valid)
//   i_reqN_rs1/rs2   32-bit operands of requester N
//   i_reqN_funct3    RV32I branch funct3 of requester N
//   i_reqN_tag       opaque TAG_W-bit tag, returned with the result
//   o_rsp_valid      result register holds a valid result
//   i_rsp_ready      consumer accepts the result this cycle
//   o_rsp_id         requester that issued the held result
//   o_rsp_tag        tag of the issuing request
//   o_rsp_taken      branch decision
//   o_rsp_equal      raw rs1 == rs2
//   o_rsp_less       raw rs1 < rs2 (signed or unsigned per funct3[1])
//   o_rsp_illegal    funct3 was 010 or 011 (not a branch encoding)
// ============================================================================
module cmp_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,

    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [31:0]      i_req0_rs1,
    input  logic [31:0]      i_req0_rs2,
    input  logic [2:0]       i_req0_funct3,
    input  logic [TAG_W-1:0] i_req0_tag,

    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [31:0]      i_req1_rs1,
    input  logic [31:0]      i_req1_rs2,
    input  logic [2:0]       i_req1_funct3,
    input  logic [TAG_W-1:0] i_req1_tag,

    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_rsp_taken,
    output logic             o_rsp_equal,
    output logic             o_rsp_less,
    output logic             o_rsp_illegal
);

    // ------------------------------------------------------------------------
    // Types and helpers
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Evaluate one branch compare and return {taken, equal, less, illegal}.
    // The operands are widened to 33 bits: sign-extended for signed ops,
    // zero-extended for unsigned ops. Bit 32 of the single difference is then
    // the correct "less" flag in both cases, and a zero difference means equal.
    function automatic logic [3:0] branch_eval(
        input logic [2:0]  funct3,
        input logic [31:0] rs1,
        input logic [31:0] rs2
    );
        logic        is_signed;
        logic [32:0] diff;
        logic        equal;
        logic        less;
        logic        taken;
        logic        illegal;
        is_signed = ~funct3[1];
        diff      = {is_signed & rs1[31], rs1} - {is_signed & rs2[31], rs2};
        equal     = (diff == 33'd0);
        less      = diff[32];
        taken     = 1'b0;
        illegal   = 1'b0;
        case (funct3)
            3'b000:         taken = equal;
            3'b001:         taken = ~equal;
            3'b100, 3'b110: taken = less;
            3'b101, 3'b111: taken = ~less;
            3'b010, 3'b011: begin
                taken   = 1'b0;
                illegal = 1'b1;
            end
            default: begin
                taken   = 1'b0;
                illegal = 1'b1;
            end
        endcase
        return {taken, equal, less, illegal};
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t             state_r;
    state_t             state_next_s;
    logic               last_grant_r;    // id of the last handshake winner

    logic               grant_valid_s;
    logic               grant_id_s;
    logic               can_accept_s;
    logic               handshake_s;

    logic [31:0]        sel_rs1_s;
    logic [31:0]        sel_rs2_s;
    logic [2:0]         sel_funct3_s;
    logic [TAG_W-1:0]   sel_tag_s;
    logic [3:0]         cmp_result_s;

    logic               rsp_id_r;
    logic [TAG_W-1:0]   rsp_tag_r;
    logic               rsp_taken_r;
    logic               rsp_equal_r;
    logic               rsp_less_r;
    logic               rsp_illegal_r;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------

    // Round-robin grant: a lone valid requester wins. When both are valid,
    // the requester that did not win the last handshake wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_grant_r;
        end else if (i_req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (i_req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Result slot is free when empty or when it is being drained this cycle.
    // Nothing is accepted while reset is asserted.
    always_comb begin
        can_accept_s = 1'b0;
        if (i_reset) begin
            can_accept_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: can_accept_s = 1'b1;
                ST_FULL:  can_accept_s = i_rsp_ready;
                default:  can_accept_s = 1'b0;
            endcase
        end
    end

    assign handshake_s  = can_accept_s & grant_valid_s;
    assign o_req0_ready = handshake_s & ~grant_id_s;
    assign o_req1_ready = handshake_s &  grant_id_s;

    // Winner tracking moves only when a request is actually accepted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_grant_r <= 1'b1;
        end else if (handshake_s) begin
            last_grant_r <= grant_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // ------------------------------------------------------------------------
    // Shared comparator
    // ------------------------------------------------------------------------

    // Steer the granted requester's fields onto the single comparator.
    always_comb begin
        sel_rs1_s    = 32'd0;
        sel_rs2_s    = 32'd0;
        sel_funct3_s = 3'd0;
        sel_tag_s    = {TAG_W{1'b0}};
        if (grant_id_s) begin
            sel_rs1_s    = i_req1_rs1;
            sel_rs2_s    = i_req1_rs2;
            sel_funct3_s = i_req1_funct3;
            sel_tag_s    = i_req1_tag;
        end else begin
            sel_rs1_s    = i_req0_rs1;
            sel_rs2_s    = i_req0_rs2;
            sel_funct3_s = i_req0_funct3;
            sel_tag_s    = i_req0_tag;
        end
    end

    assign cmp_result_s = branch_eval(sel_funct3_s, sel_rs1_s, sel_rs2_s);

    // ------------------------------------------------------------------------
    // Result register state machine
    // ------------------------------------------------------------------------

    // State register for the one-entry result slot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: fill on handshake, empty on drain without refill, else hold.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (handshake_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (handshake_s) begin
                    state_next_s = ST_FULL;
                end else if (i_rsp_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Capture the result payload on handshake; hold it otherwise so a stalled
    // consumer sees stable outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rsp_id_r      <= 1'b0;
            rsp_tag_r     <= {TAG_W{1'b0}};
            rsp_taken_r   <= 1'b0;
            rsp_equal_r   <= 1'b0;
            rsp_less_r    <= 1'b0;
            rsp_illegal_r <= 1'b0;
        end else if (handshake_s) begin
            rsp_id_r      <= grant_id_s;
            rsp_tag_r     <= sel_tag_s;
            rsp_taken_r   <= cmp_result_s[3];
            rsp_equal_r   <= cmp_result_s[2];
            rsp_less_r    <= cmp_result_s[1];
            rsp_illegal_r <= cmp_result_s[0];
        end else begin
            rsp_id_r      <= rsp_id_r;
            rsp_tag_r     <= rsp_tag_r;
            rsp_taken_r   <= rsp_taken_r;
            rsp_equal_r   <= rsp_equal_r;
            rsp_less_r    <= rsp_less_r;
            rsp_illegal_r <= rsp_illegal_r;
        end
    end

    assign o_rsp_valid   = (state_r == ST_FULL);
    assign o_rsp_id      = rsp_id_r;
    assign o_rsp_tag     = rsp_tag_r;
    assign o_rsp_taken   = rsp_taken_r;
    assign o_rsp_equal   = rsp_equal_r;
    assign o_rsp_less    = rsp_less_r;
    assign o_rsp_illegal = rsp_illegal_r;

endmodule

// File: tb/tb_cmp_arbiter.sv
// ============================================================================
// tb_cmp_arbiter
// Self-checking bench for cmp_arbiter. Inputs are driven 1 time unit after
// the rising edge. Outputs are compared on the falling edge against a
// behavioural model that holds the expected result slot contents and the
// last winner. Expected compare flags come from plain integer comparisons.
// ============================================================================
module tb_cmp_arbiter;
    localparam int TAG_W = 4;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_req0_valid, i_req1_valid;
    logic             o_req0_ready, o_req1_ready;
    logic [31:0]      i_req0_rs1, i_req0_rs2, i_req1_rs1, i_req1_rs2;
    logic [2:0]       i_req0_funct3, i_req1_funct3;
    logic [TAG_W-1:0] i_req0_tag, i_req1_tag;
    logic             o_rsp_valid, i_rsp_ready, o_rsp_id;
    logic [TAG_W-1:0] o_rsp_tag;
    logic             o_rsp_taken, o_rsp_equal, o_rsp_less, o_rsp_illegal;

    cmp_arbiter #(.TAG_W(TAG_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_rs1(i_req0_rs1), .i_req0_rs2(i_req0_rs2),
        .i_req0_funct3(i_req0_funct3), .i_req0_tag(i_req0_tag),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_rs1(i_req1_rs1), .i_req1_rs2(i_req1_rs2),
        .i_req1_funct3(i_req1_funct3), .i_req1_tag(i_req1_tag),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_id(o_rsp_id), .o_rsp_tag(o_rsp_tag),
        .o_rsp_taken(o_rsp_taken), .o_rsp_equal(o_rsp_equal),
        .o_rsp_less(o_rsp_less), .o_rsp_illegal(o_rsp_illegal)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit               m_full;
    bit               m_last;       // winner of last handshake
    bit               m_id;
    logic [TAG_W-1:0] m_tag;
    bit               m_taken, m_equal, m_less, m_illegal;
    bit               last_hs0, last_hs1;

    // Branch semantics straight from the RV32I definition.
    function automatic void ref_eval(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b, output bit taken,
                                     output bit equal, output bit less,
                                     output bit illegal);
        equal   = (a == b);
        less    = f3[1] ? (a < b) : ($signed(a) < $signed(b));
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000:         taken = equal;
            3'b001:         taken = !equal;
            3'b100, 3'b110: taken = less;
            3'b101, 3'b111: taken = !less;
            default:        taken = 1'b0;
        endcase
    endfunction

    // Expected ready for requester n given current inputs and model state.
    function automatic bit exp_ready(input int n);
        int winner;
        if (i_reset) return 1'b0;
        if (i_req0_valid && i_req1_valid) winner = m_last ? 0 : 1;
        else if (i_req0_valid)            winner = 0;
        else if (i_req1_valid)            winner = 1;
        else                              winner = -1;
        return (!m_full || i_rsp_ready) && (winner == n);
    endfunction

    function automatic logic [8:0] exp_rsp();
        return {m_id, m_tag, m_taken, m_equal, m_less, m_illegal};
    endfunction

    function automatic logic [8:0] dut_rsp();
        return {o_rsp_id, o_rsp_tag, o_rsp_taken, o_rsp_equal, o_rsp_less, o_rsp_illegal};
    endfunction

    task automatic set_req(input int n, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] f,
                           input logic [TAG_W-1:0] t);
        if (n == 0) begin
            i_req0_valid = v; i_req0_rs1 = a; i_req0_rs2 = b;
            i_req0_funct3 = f; i_req0_tag = t;
        end else begin
            i_req1_valid = v; i_req1_rs1 = a; i_req1_rs2 = b;
            i_req1_funct3 = f; i_req1_tag = t;
        end
    endtask

    task automatic set_rand(input int n, input bit v);
        set_req(n, v, $urandom, $urandom, 3'($urandom_range(0, 7)),
                TAG_W'($urandom_range(0, 15)));
    endtask

    // Advance one clock and update the model with what the edge does.
    task automatic tick();
        bit t, e, l, il;
        last_hs0 = i_req0_valid && exp_ready(0);
        last_hs1 = i_req1_valid && exp_ready(1);
        @(posedge i_clk);
        if (i_reset) begin
            m_full = 0; m_last = 1; m_id = 0; m_tag = '0;
            m_taken = 0; m_equal = 0; m_less = 0; m_illegal = 0;
        end else if (last_hs0 || last_hs1) begin
            if (last_hs0) begin
                ref_eval(i_req0_funct3, i_req0_rs1, i_req0_rs2, t, e, l, il);
                m_tag = i_req0_tag;
            end else begin
                ref_eval(i_req1_funct3, i_req1_rs1, i_req1_rs2, t, e, l, il);
                m_tag = i_req1_tag;
            end
            m_full = 1; m_id = last_hs1; m_last = last_hs1;
            m_taken = t; m_equal = e; m_less = l; m_illegal = il;
        end else if (m_full && i_rsp_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_rsp_ready = 1'b1;
        set_rand(0, 1'b1); set_rand(1, 1'b1);
        tick();
        @(negedge i_clk);
        checks++;
        if ({o_req0_ready, o_req1_ready} !== 2'b00) begin
            failures++; $display("FAIL reset_ready: got %b expected 00", {o_req0_ready, o_req1_ready});
        end
        checks++;
        if ({o_rsp_valid, dut_rsp()} !== 10'd0) begin
            failures++; $display("FAIL reset_rsp: got %h expected 000", {o_rsp_valid, dut_rsp()});
        end
        tick();
        i_reset = 1'b0;
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
    endtask

    task automatic test_directed();
        i_rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 4'd3);
        @(negedge i_clk);
        checks++;
        if (o_req0_ready !== 1'b1) begin
            failures++; $display("FAIL blt_ready: got %b expected 1", o_req0_ready);
        end
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 4'd5);
        @(negedge i_clk);
        checks++;
        if ({o_rsp_valid, dut_rsp()} !== {1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL blt_rsp: got %h expected %h", {o_rsp_valid, dut_rsp()},
                                 {1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        checks++;
        if (o_req1_ready !== 1'b1) begin
            failures++; $display("FAIL bltu_ready: got %b expected 1", o_req1_ready);
        end
        tick();
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 4'd6);
        @(negedge i_clk);
        checks++;
        if ({o_rsp_valid, dut_rsp()} !== {1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL bltu_rsp: got %h expected %h", {o_rsp_valid, dut_rsp()},
                                 {1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
        set_req(0, 1'b1, 32'd7, 32'd7, 3'b010, 4'd9);
        @(negedge i_clk);
        checks++;
        if ({o_rsp_valid, dut_rsp()} !== {1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL bgeu_rsp: got %h expected %h", {o_rsp_valid, dut_rsp()},
                                 {1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
        @(negedge i_clk);
        checks++;
        if ({o_rsp_valid, dut_rsp()} !== {1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL illegal_rsp: got %h expected %h", {o_rsp_valid, dut_rsp()},
                                 {1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1});
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL drain_empty: got %b expected 0", o_rsp_valid);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_rand(0, 1'b1); set_rand(1, 1'b1);
            @(negedge i_clk);
            checks++;
            if ({o_req0_ready, o_req1_ready} !== {k % 2 == 0, k % 2 == 1}) begin
                failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", k,
                                     {o_req0_ready, o_req1_ready}, {k % 2 == 0, k % 2 == 1});
            end
            if (k > 0) begin
                checks++;
                if ({o_rsp_valid, dut_rsp()} !== {1'b1, exp_rsp()} || o_rsp_id !== 1'((k - 1) % 2)) begin
                    failures++; $display("FAIL rr_rsp[%0d]: got %h expected %h", k,
                                         {o_rsp_valid, dut_rsp()}, {1'b1, exp_rsp()});
                end
            end
            tick();
        end
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_rsp_valid, dut_rsp()} !== {1'b1, exp_rsp()} || o_rsp_id !== 1'b0) begin
            failures++; $display("FAIL rr_last: got %h expected %h", {o_rsp_valid, dut_rsp()}, {1'b1, exp_rsp()});
        end
        tick();
    endtask

    task automatic test_backpressure();
        i_rsp_ready = 1'b1;
        set_rand(0, 1'b1); set_rand(1, 1'b1);
        @(negedge i_clk);
        checks++;
        if ({o_req0_ready, o_req1_ready} !== 2'b01) begin
            failures++; $display("FAIL bp_first: got %b expected 01", {o_req0_ready, o_req1_ready});
        end
        tick();
        i_rsp_ready = 1'b0;
        set_rand(1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checks++;
            if ({o_req0_ready, o_req1_ready, o_rsp_valid, dut_rsp()} !== {2'b00, 1'b1, exp_rsp()}
                || o_rsp_id !== 1'b1) begin
                failures++; $display("FAIL bp_hold[%0d]: got %h expected %h", k,
                                     {o_req0_ready, o_req1_ready, o_rsp_valid, dut_rsp()},
                                     {2'b00, 1'b1, exp_rsp()});
            end
            tick();
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        checks++;
        if ({o_req0_ready, o_req1_ready} !== 2'b10) begin
            failures++; $display("FAIL bp_release: got %b expected 10", {o_req0_ready, o_req1_ready});
        end
        tick();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_rsp_valid, dut_rsp()} !== {1'b1, exp_rsp()} || o_rsp_id !== 1'b0) begin
            failures++; $display("FAIL bp_refill: got %h expected %h", {o_rsp_valid, dut_rsp()}, {1'b1, exp_rsp()});
        end
        tick();
    endtask

    task automatic test_reset_midop();
        i_rsp_ready = 1'b1;
        set_rand(0, 1'b1);
        tick();
        i_rsp_ready = 1'b0; i_req0_valid = 1'b0;
        tick();
        i_reset = 1'b1;
        set_rand(0, 1'b1); set_rand(1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            checks++;
            if ({o_req0_ready, o_req1_ready} !== 2'b00 || (k == 1 && o_rsp_valid !== 1'b0)) begin
                failures++; $display("FAIL midrst[%0d]: got %b expected 000", k,
                                     {o_req0_ready, o_req1_ready, o_rsp_valid});
            end
            tick();
        end
        i_reset = 1'b0; i_req0_valid = 1'b0;
        set_rand(1, 1'b1);
        @(negedge i_clk);
        checks++;
        if ({o_rsp_valid, o_req0_ready, o_req1_ready} !== 3'b001) begin
            failures++; $display("FAIL midrst_req1: got %b expected 001", {o_rsp_valid, o_req0_ready, o_req1_ready});
        end
        tick();
        i_req1_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_rsp_valid, dut_rsp()} !== {1'b1, exp_rsp()} || o_rsp_id !== 1'b1) begin
            failures++; $display("FAIL midrst_rsp: got %h expected %h", {o_rsp_valid, dut_rsp()}, {1'b1, exp_rsp()});
        end
        i_rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit pend0, pend1;
        logic [31:0] a;
        pend0 = 0; pend1 = 0;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!(n == 0 ? pend0 : pend1)) begin
                    a = $urandom;
                    if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3));
                    set_req(n, $urandom_range(0, 99) < 60, a,
                            ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom),
                            3'($urandom_range(0, 7)), TAG_W'($urandom_range(0, 15)));
                end
            end
            i_rsp_ready = $urandom_range(0, 99) < 65;
            i_reset     = $urandom_range(0, 99) == 0;
            @(negedge i_clk);
            checks++;
            if ({o_req0_ready, o_req1_ready, o_rsp_valid} !== {exp_ready(0), exp_ready(1), m_full}) begin
                failures++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", c,
                                     {o_req0_ready, o_req1_ready, o_rsp_valid},
                                     {exp_ready(0), exp_ready(1), m_full});
            end
            if (m_full) begin
                checks++;
                if (dut_rsp() !== exp_rsp()) begin
                    failures++; $display("FAIL rand_rsp[%0d]: got %h expected %h", c, dut_rsp(), exp_rsp());
                end
            end
            tick();
            pend0 = i_req0_valid && !last_hs0;
            pend1 = i_req1_valid && !last_hs1;
        end
        i_reset = 1'b0;
    endtask

    initial begin
        m_full = 0; m_last = 1; m_id = 0; m_tag = '0;
        m_taken = 0; m_equal = 0; m_less = 0; m_illegal = 0;
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
